// File: rtl/memShare_config_pkg.sv
// Memory-share configuration: DRC flag vector layout shared across blocks.
package memShare_config_pkg;

  localparam int unsigned MEMSHARE_DRC_NUM = 2;
  localparam int unsigned MEMSHARE_DRC1    = 1;

endpackage

// File: rtl/msgPass_config_pkg.sv
// Message-pass configuration: default field widths and read scheduler states.
package msgPass_config_pkg;

  localparam int unsigned RD_LEN_WIDTH_DEF     = 8;
  localparam int unsigned DRC_PERIOD_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEGIN = 2'd1,
    ST_READ  = 2'd2,
    ST_END   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/msgpass_drc_tick.sv
// Modulo-period phase counter; ticks on the last read of each DRC period.
module msgpass_drc_tick #(
  parameter int unsigned DRC_PERIOD_WIDTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic                        adv,
  input  logic [DRC_PERIOD_WIDTH-1:0] period,
  output logic                        tick
);

  logic [DRC_PERIOD_WIDTH-1:0] phase_q;
  logic [DRC_PERIOD_WIDTH-1:0] last_phase;

  // Last phase of the period; a zero period never ticks.
  always_comb begin
    last_phase = period - DRC_PERIOD_WIDTH'(1);
    tick       = (period != '0) && (phase_q == last_phase);
  end

  // Phase advances once per read and wraps at the period boundary.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
    end else if (clr) begin
      phase_q <= '0;
    end else if (adv) begin
      phase_q <= (phase_q == last_phase) ? '0 : phase_q + DRC_PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/msgpass_rd_sched.sv
// Message-pass buffer read scheduler: one begin/read*N/end session per start.
module msgpass_rd_sched
  import msgPass_config_pkg::*;
  import memShare_config_pkg::*;
#(
  parameter int unsigned RD_LEN_WIDTH     = RD_LEN_WIDTH_DEF,
  parameter int unsigned DRC_PERIOD_WIDTH = DRC_PERIOD_WIDTH_DEF
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        layer_start_i,
  input  logic [RD_LEN_WIDTH-1:0]     rd_len_i,
  input  logic [DRC_PERIOD_WIDTH-1:0] drc_period_i,
  input  logic                        stall_i,
  output logic                        buffer_read_begin_o,
  output logic                        buffer_read_end_o,
  output logic [MEMSHARE_DRC_NUM-1:0] is_drc_o,
  output logic                        rd_en_o,
  output logic [RD_LEN_WIDTH-1:0]     rd_idx_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        start_err_o
);

  rd_state_e                   state_q, state_d;
  logic [RD_LEN_WIDTH-1:0]     len_q;
  logic [DRC_PERIOD_WIDTH-1:0] period_q;
  logic [RD_LEN_WIDTH-1:0]     cnt_q;
  logic                        err_q;
  logic [RD_LEN_WIDTH-1:0]     last_idx;
  logic                        begin_pulse;
  logic                        end_pulse;
  logic                        rd_en;
  logic                        drc_tick;

  assign last_idx = len_q - RD_LEN_WIDTH'(1);

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_d     = state_q;
    begin_pulse = 1'b0;
    end_pulse   = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (layer_start_i) state_d = ST_BEGIN;
      end
      ST_BEGIN: begin
        begin_pulse = 1'b1;
        state_d     = (len_q != '0) ? ST_READ : ST_END;
      end
      ST_READ: begin
        rd_en = !stall_i;
        if (!stall_i && (cnt_q == last_idx)) state_d = ST_END;
      end
      ST_END: begin
        end_pulse = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Session fields, read counter and sticky start-while-busy flag.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      len_q    <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && layer_start_i) begin
        len_q    <= rd_len_i;
        period_q <= drc_period_i;
        cnt_q    <= '0;
      end
      if ((state_q != ST_IDLE) && layer_start_i) begin
        err_q <= 1'b1;
      end
      // The counter parks on the final index so all-ones lengths never wrap.
      if ((state_q == ST_READ) && !stall_i && (cnt_q != last_idx)) begin
        cnt_q <= cnt_q + RD_LEN_WIDTH'(1);
      end
    end
  end

  msgpass_drc_tick #(
    .DRC_PERIOD_WIDTH(DRC_PERIOD_WIDTH)
  ) u_drc_tick (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .clr     (state_q == ST_BEGIN),
    .adv     (rd_en),
    .period  (period_q),
    .tick    (drc_tick)
  );

  // DRC flag vector: only DRC1 is driven, and only on an actual read.
  always_comb begin
    is_drc_o                = '0;
    is_drc_o[MEMSHARE_DRC1] = rd_en & drc_tick;
  end

  assign buffer_read_begin_o = begin_pulse;
  assign buffer_read_end_o   = end_pulse;
  assign done_o              = end_pulse;
  assign rd_en_o             = rd_en;
  assign rd_idx_o            = cnt_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign start_err_o         = err_q;

endmodule

// File: tb/tb_msgpass_rd_sched.sv
// Directed bench for msgpass_rd_sched with hand-computed expectations.
module tb_msgpass_rd_sched;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       layer_start_i;
  logic [7:0] rd_len_i;
  logic [3:0] drc_period_i;
  logic       stall_i;
  logic       buffer_read_begin_o;
  logic       buffer_read_end_o;
  logic [1:0] is_drc_o;
  logic       rd_en_o;
  logic [7:0] rd_idx_o;
  logic       busy_o;
  logic       done_o;
  logic       start_err_o;

  int errors = 0;
  int checks = 0;

  logic       rec_rd_en [600];
  logic [7:0] rec_idx   [600];
  logic [1:0] rec_drc   [600];
  logic       rec_beg   [600];
  logic       rec_end   [600];
  logic       rec_done  [600];
  logic       rec_busy  [600];
  logic       rec_err   [600];
  int         end_cyc;
  int         ncyc;

  always #5 sys_clk = ~sys_clk;

  msgpass_rd_sched #(
    .RD_LEN_WIDTH(8),
    .DRC_PERIOD_WIDTH(4)
  ) dut (
    .sys_clk             (sys_clk),
    .rstn                (rstn),
    .layer_start_i       (layer_start_i),
    .rd_len_i            (rd_len_i),
    .drc_period_i        (drc_period_i),
    .stall_i             (stall_i),
    .buffer_read_begin_o (buffer_read_begin_o),
    .buffer_read_end_o   (buffer_read_end_o),
    .is_drc_o            (is_drc_o),
    .rd_en_o             (rd_en_o),
    .rd_idx_o            (rd_idx_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .start_err_o         (start_err_o)
  );

  // Runs one session starting in cycle 0 and records every cycle's outputs.
  task automatic do_session(input int len, input int per, input int stall_at,
                            input int stall_n, input int s2_at, input int s2_len);
    end_cyc = -1;
    ncyc    = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge sys_clk); #1;
      layer_start_i = (c == 0) || (c == s2_at);
      rd_len_i      = 8'((c == 0) ? len : s2_len);
      drc_period_i  = 4'(per);
      stall_i       = (stall_n > 0) && (c >= stall_at) && (c < stall_at + stall_n);
      #1;
      rec_rd_en[c] = rd_en_o;
      rec_idx[c]   = rd_idx_o;
      rec_drc[c]   = is_drc_o;
      rec_beg[c]   = buffer_read_begin_o;
      rec_end[c]   = buffer_read_end_o;
      rec_done[c]  = done_o;
      rec_busy[c]  = busy_o;
      rec_err[c]   = start_err_o;
      ncyc = c + 1;
      if (buffer_read_end_o && end_cyc < 0) end_cyc = c;
      if (end_cyc >= 0 && c == end_cyc + 2) break;
    end
    layer_start_i = 1'b0;
    stall_i       = 1'b0;
    checks++;
    if (end_cyc < 0) begin
      errors++;
      $display("FAIL session_timeout: len=%0d no end pulse within %0d cycles", len, ncyc);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    layer_start_i = 1'b0; rd_len_i = '0; drc_period_i = '0; stall_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (rd_en_o !== 1'b0)     begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en_o); end
    checks++; if (rd_idx_o !== 8'd0)    begin errors++; $display("FAIL reset_idx: got %0d want 0", rd_idx_o); end
    checks++; if (is_drc_o !== 2'b00)   begin errors++; $display("FAIL reset_drc: got %b want 00", is_drc_o); end
    checks++; if (buffer_read_begin_o !== 1'b0 || buffer_read_end_o !== 1'b0 || done_o !== 1'b0)
      begin errors++; $display("FAIL reset_pulses: got beg=%b end=%b done=%b want 0", buffer_read_begin_o, buffer_read_end_o, done_o); end
    checks++; if (start_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", start_err_o); end
    rstn = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++; if (busy_o !== 1'b0 || rd_en_o !== 1'b0)
      begin errors++; $display("FAIL post_reset_idle: got busy=%b rd_en=%b want 0", busy_o, rd_en_o); end
  endtask

  task automatic test_basic();
    int nb;
    do_session(4, 0, 0, 0, -1, 0);
    nb = 0;
    for (int c = 0; c < ncyc; c++) begin
      logic exp_en;
      if (rec_beg[c]) nb++;
      exp_en = (c >= 2 && c <= 5);
      checks++; if (rec_rd_en[c] !== exp_en) begin errors++; $display("FAIL basic_rd_en c=%0d: got %b want %b", c, rec_rd_en[c], exp_en); end
      if (exp_en) begin
        checks++; if (rec_idx[c] !== 8'(c - 2)) begin errors++; $display("FAIL basic_idx c=%0d: got %0d want %0d", c, rec_idx[c], c - 2); end
      end
      checks++; if (rec_drc[c] !== 2'b00) begin errors++; $display("FAIL basic_drc c=%0d: got %b want 00", c, rec_drc[c]); end
    end
    checks++; if (rec_beg[1] !== 1'b1 || nb != 1) begin errors++; $display("FAIL basic_begin: got beg@1=%b count=%0d want 1,1", rec_beg[1], nb); end
    checks++; if (end_cyc != 6) begin errors++; $display("FAIL basic_end_cycle: got %0d want 6", end_cyc); end
    checks++; if (rec_done[6] !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", rec_done[6]); end
    checks++; if (rec_idx[7] !== 8'd3 || rec_busy[7] !== 1'b0)
      begin errors++; $display("FAIL basic_after_end: got idx=%0d busy=%b want 3,0", rec_idx[7], rec_busy[7]); end
  endtask

  task automatic test_drc();
    do_session(6, 3, 0, 0, -1, 0);
    checks++; if (end_cyc != 8) begin errors++; $display("FAIL drc_end_cycle: got %0d want 8", end_cyc); end
    for (int c = 0; c < ncyc; c++) begin
      logic [1:0] exp_drc;
      exp_drc = (c == 4 || c == 7) ? 2'b10 : 2'b00;
      checks++; if (rec_drc[c] !== exp_drc) begin errors++; $display("FAIL drc_flag c=%0d: got %b want %b", c, rec_drc[c], exp_drc); end
    end
  endtask

  task automatic test_stall();
    logic       exp_en  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_idx [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
    do_session(3, 2, 3, 2, -1, 0);
    checks++; if (end_cyc != 7) begin errors++; $display("FAIL stall_end_cycle: got %0d want 7", end_cyc); end
    for (int c = 0; c < 8; c++) begin
      logic [1:0] exp_drc;
      exp_drc = (c == 5) ? 2'b10 : 2'b00;
      checks++; if (rec_rd_en[c] !== exp_en[c]) begin errors++; $display("FAIL stall_rd_en c=%0d: got %b want %b", c, rec_rd_en[c], exp_en[c]); end
      if (c >= 2) begin
        checks++; if (rec_idx[c] !== exp_idx[c]) begin errors++; $display("FAIL stall_idx c=%0d: got %0d want %0d", c, rec_idx[c], exp_idx[c]); end
      end
      checks++; if (rec_drc[c] !== exp_drc) begin errors++; $display("FAIL stall_drc c=%0d: got %b want %b", c, rec_drc[c], exp_drc); end
    end
  endtask

  task automatic test_zero_len();
    int nrd;
    do_session(0, 5, 0, 0, -1, 0);
    nrd = 0;
    for (int c = 0; c < ncyc; c++) if (rec_rd_en[c] === 1'b1) nrd++;
    checks++; if (rec_beg[1] !== 1'b1) begin errors++; $display("FAIL zero_begin: got %b want 1", rec_beg[1]); end
    checks++; if (end_cyc != 2 || rec_done[2] !== 1'b1) begin errors++; $display("FAIL zero_end: got cyc=%0d done=%b want 2,1", end_cyc, rec_done[2]); end
    checks++; if (nrd != 0) begin errors++; $display("FAIL zero_rd_en: got %0d reads want 0", nrd); end
    checks++; if (rec_idx[1] !== 8'd0) begin errors++; $display("FAIL zero_idx_clear: got %0d want 0", rec_idx[1]); end
  endtask

  task automatic test_max_len();
    int nrd, ndrc;
    do_session(255, 15, 0, 0, -1, 0);
    nrd = 0; ndrc = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (rec_rd_en[c] === 1'b1) nrd++;
      if (rec_drc[c] === 2'b10) ndrc++;
    end
    checks++; if (end_cyc != 257) begin errors++; $display("FAIL max_end_cycle: got %0d want 257", end_cyc); end
    checks++; if (nrd != 255) begin errors++; $display("FAIL max_reads: got %0d want 255", nrd); end
    checks++; if (ndrc != 17) begin errors++; $display("FAIL max_drc_count: got %0d want 17", ndrc); end
    checks++; if (rec_idx[256] !== 8'd254 || rec_drc[256] !== 2'b10)
      begin errors++; $display("FAIL max_last_read: got idx=%0d drc=%b want 254,10", rec_idx[256], rec_drc[256]); end
    checks++; if (rec_idx[258] !== 8'd254) begin errors++; $display("FAIL max_idx_hold: got %0d want 254", rec_idx[258]); end
  endtask

  task automatic test_start_while_busy();
    int nrd, nb;
    do_session(5, 0, 0, 0, 4, 9);
    nrd = 0; nb = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (rec_rd_en[c] === 1'b1) nrd++;
      if (rec_beg[c] === 1'b1) nb++;
    end
    checks++; if (end_cyc != 7) begin errors++; $display("FAIL busy_start_end_cycle: got %0d want 7", end_cyc); end
    checks++; if (nrd != 5 || nb != 1) begin errors++; $display("FAIL busy_start_reads: got reads=%0d begins=%0d want 5,1", nrd, nb); end
    checks++; if (rec_err[4] !== 1'b0 || rec_err[5] !== 1'b1)
      begin errors++; $display("FAIL busy_start_err_set: got @4=%b @5=%b want 0,1", rec_err[4], rec_err[5]); end
    do_session(2, 0, 0, 0, -1, 0);
    checks++; if (end_cyc != 4) begin errors++; $display("FAIL busy_followup_end: got %0d want 4", end_cyc); end
    checks++; if (rec_err[0] !== 1'b1 || rec_err[ncyc-1] !== 1'b1)
      begin errors++; $display("FAIL busy_err_sticky: got %b/%b want 1/1", rec_err[0], rec_err[ncyc-1]); end
  endtask

  task automatic test_reset_mid_read();
    @(posedge sys_clk); #1;
    layer_start_i = 1'b1; rd_len_i = 8'd8; drc_period_i = 4'd1;
    @(posedge sys_clk); #1;
    layer_start_i = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++; if (rd_en_o !== 1'b1 || busy_o !== 1'b1 || rd_idx_o !== 8'd1)
      begin errors++; $display("FAIL midrst_pre: got rd_en=%b busy=%b idx=%0d want 1,1,1", rd_en_o, busy_o, rd_idx_o); end
    rstn = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || rd_en_o !== 1'b0 || rd_idx_o !== 8'd0 || is_drc_o !== 2'b00)
      begin errors++; $display("FAIL midrst_outputs: got busy=%b rd_en=%b idx=%0d drc=%b want 0", busy_o, rd_en_o, rd_idx_o, is_drc_o); end
    checks++; if (start_err_o !== 1'b0) begin errors++; $display("FAIL midrst_err_clear: got %b want 0", start_err_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      checks++; if (buffer_read_end_o !== 1'b0 || done_o !== 1'b0)
        begin errors++; $display("FAIL midrst_no_end i=%0d: got end=%b done=%b want 0", i, buffer_read_end_o, done_o); end
    end
    rstn = 1'b1;
    do_session(2, 0, 0, 0, -1, 0);
    checks++; if (rec_beg[1] !== 1'b1 || end_cyc != 4) begin errors++; $display("FAIL midrst_clean_session: got beg@1=%b end=%0d want 1,4", rec_beg[1], end_cyc); end
    checks++; if (rec_rd_en[2] !== 1'b1 || rec_idx[2] !== 8'd0 || rec_rd_en[3] !== 1'b1 || rec_idx[3] !== 8'd1)
      begin errors++; $display("FAIL midrst_clean_reads: got %b/%0d %b/%0d want 1/0 1/1", rec_rd_en[2], rec_idx[2], rec_rd_en[3], rec_idx[3]); end
    checks++; if (rec_err[ncyc-1] !== 1'b0) begin errors++; $display("FAIL midrst_clean_err: got %b want 0", rec_err[ncyc-1]); end
  endtask

  task automatic test_start_at_end();
    do_session(1, 0, 0, 0, 3, 5);
    checks++; if (end_cyc != 3) begin errors++; $display("FAIL endcoll_end_cycle: got %0d want 3", end_cyc); end
    checks++; if (rec_beg[4] !== 1'b0 || rec_busy[4] !== 1'b0)
      begin errors++; $display("FAIL endcoll_ignored: got beg=%b busy=%b want 0,0", rec_beg[4], rec_busy[4]); end
    checks++; if (rec_err[3] !== 1'b0 || rec_err[4] !== 1'b1)
      begin errors++; $display("FAIL endcoll_err: got @3=%b @4=%b want 0,1", rec_err[3], rec_err[4]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drc();
    test_stall();
    test_zero_len();
    test_max_len();
    test_start_while_busy();
    test_reset_mid_read();
    test_start_at_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msgpass_rd_sched.md
MSGPASS_RD_SCHED -- requirements
Module: msgpass_rd_sched

Interface
REQ-001 Parameter RD_LEN_WIDTH, default 8: width of the read-length and read-index fields.
REQ-002 Parameter DRC_PERIOD_WIDTH, default 4: width of the DRC period field.
REQ-003 One clock; reset is asynchronous and active-low (ports sys_clk, rstn).
REQ-004 sys_clk  in  1  system clock, all state on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 layer_start_i  in  1  pulse, requests one read session.
REQ-007 rd_len_i  in  RD_LEN_WIDTH  number of read cycles, sampled with layer_start_i.
REQ-008 drc_period_i  in  DRC_PERIOD_WIDTH  DRC1 spacing, sampled with layer_start_i; 0 disables DRC.
REQ-009 stall_i  in  1  level, freezes read progress.
REQ-010 buffer_read_begin_o  out  1  one-cycle pulse, session opens (feeds address generator).
REQ-011 buffer_read_end_o  out  1  one-cycle pulse, session closes.
REQ-012 is_drc_o  out  MEMSHARE_DRC_NUM  per-cycle DRC flags.
REQ-013 rd_en_o  out  1  read strobe for the message-pass buffer.
REQ-014 rd_idx_o  out  RD_LEN_WIDTH  index of the current read, 0-based.
REQ-015 busy_o  out  1  high whenever state is not IDLE.
REQ-016 done_o  out  1  one-cycle pulse, coincident with buffer_read_end_o.
REQ-017 start_err_o  out  1  sticky, set when layer_start_i arrives while busy.

Function
REQ-018 FSM states IDLE, BEGIN, READ, END; encoding in package.
REQ-019 IDLE & layer_start_i: latch rd_len_i and drc_period_i, go BEGIN next cycle.
REQ-020 BEGIN: buffer_read_begin_o=1 for exactly that cycle; next state READ if latched length>0, else END.
REQ-021 READ: rd_en_o = !stall_i; rd_idx_o = internal counter (starts 0).
REQ-022 READ & !stall_i: counter increments; on counter == length-1 go END, counter not incremented past length-1.
REQ-023 READ & stall_i: counter, state, is_drc_o held; rd_en_o=0.
REQ-024 is_drc_o[MEMSHARE_DRC1] = rd_en_o & (period!=0) & ((counter mod period) == period-1); all other bits 0.
REQ-025 END: buffer_read_end_o=1, done_o=1 for one cycle; next state IDLE.
REQ-026 Latency: start at cycle t -> begin at t+1 -> first rd_en at t+2 (no stall) -> end at t+2+len; len=0 -> end at t+2.
REQ-027 layer_start_i in any non-IDLE state ignored (latched values unchanged) and sets start_err_o.
REQ-028 layer_start_i in the same cycle as END completion is ignored and flags start_err_o; new session needs IDLE.
REQ-029 rd_len_i all-ones is legal: 2^RD_LEN_WIDTH-1 reads, counter never wraps.
REQ-030 Outside READ: rd_en_o=0, is_drc_o=0, rd_idx_o holds last value until next BEGIN, where it clears to 0.

Reset
REQ-031 rstn low asynchronously forces IDLE, counter 0, latched fields 0, start_err_o 0.
REQ-032 All outputs 0 during and after reset until a start; reset mid-session aborts without emitting buffer_read_end_o.

Structure
REQ-033 FSM state typedef and RD_LEN_WIDTH/DRC_PERIOD_WIDTH defaults in msgPass_config_pkg; MEMSHARE_DRC_NUM, MEMSHARE_DRC1 from memShare_config_pkg.
REQ-034 Single sub-module msgpass_drc_tick: modulo-period counter producing the DRC1 tick, advanced by rd_en_o, cleared in BEGIN.
REQ-035 All outputs registered or decoded from registered state only; no gated clocks.

Verification
REQ-036 rd_len=4, period=0, no stall -> begin@t+1, rd_en t+2..t+5, rd_idx 0..3, end+done@t+6, is_drc all 0.
REQ-037 rd_len=6, period=3 -> is_drc[DRC1]=1 on rd_idx 2 and 5 only.
REQ-038 rd_len=3, stall_i high on the 2nd read cycle for 2 cycles -> rd_en gaps 2 cycles, rd_idx holds 1, end@t+7.
REQ-039 rd_len=0 -> begin@t+1, end+done@t+2, rd_en never high.
REQ-040 Second layer_start_i during READ -> ignored, session length unchanged, start_err_o=1 until reset.
REQ-041 rstn pulled low mid-READ -> all outputs 0 immediately, no end pulse; next start runs a full clean session.
